// File: rtl/fpu_pkg.sv
// fpu_pkg: shared operation encodings and binary32/binary16 constants
package fpu_pkg;
    typedef enum logic [1:0] {
        FP_ADD32 = 2'b00,
        FP_MUL32 = 2'b01,
        FP_ADD16 = 2'b10,
        FP_MUL16 = 2'b11
    } fpu_op_e;
    localparam int BIAS32 = 127;
    localparam int BIAS16 = 15;
    localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
    localparam logic [31:0] INF32  = 32'h7F80_0000;
    localparam logic [15:0] QNAN16 = 16'h7E00;
    localparam logic [15:0] INF16  = 16'h7C00;
endpackage

// File: rtl/fp_addmul_core.sv
// fp_addmul_core: combinational truncating add/multiply for one IEEE-754 format
module fp_addmul_core #(
    parameter int EW = 8,
    parameter int MW = 23,
    parameter int BIAS = 127,
    parameter logic [EW+MW:0] QNAN = '0
) (
    input  logic [EW+MW:0] a,
    input  logic [EW+MW:0] b,
    input  logic           op_mul,
    output logic [EW+MW:0] res,
    output logic [3:0]     flags
);
    localparam int W = EW + MW + 1;
    localparam int XW = MW + 1;
    localparam int EX = EW + 2;
    localparam int LZW = $clog2(XW + 5);
    localparam logic [EW-1:0] EMAX = '1;
    localparam logic [EW-1:0] DLIM = EW'(XW + 2);

    logic sa, sb, za, zb, ia, ib, na, nb, swap, sl, st, s, x, done;
    logic [EW-1:0] ea, eb, el, es, d;
    logic [MW-1:0] ma, mb, m;
    logic [XW-1:0] fa, fb, fl, fs;
    logic [2*XW+1:0] shifted;
    logic [XW+3:0] lx, sx, sum, norm;
    logic [LZW-1:0] lz;
    logic [2*XW-1:0] p, pn;
    logic [EX-1:0] add_e, mul_e, e;
    logic ovf, unf;

    assign {sa, ea, ma} = a;
    assign {sb, eb, mb} = b;
    assign za = ea == '0;
    assign zb = eb == '0;
    assign ia = ea == EMAX && ma == '0;
    assign ib = eb == EMAX && mb == '0;
    assign na = ea == EMAX && ma != '0;
    assign nb = eb == EMAX && mb != '0;
    // Subnormal inputs contribute no significand, so they behave as signed zero
    assign fa = za ? '0 : {1'b1, ma};
    assign fb = zb ? '0 : {1'b1, mb};

    // The larger magnitude leads; its sign is the sign of the sum
    assign swap = {eb, mb} > {ea, ma};
    assign {sl, el, fl} = swap ? {sb, eb, fb} : {sa, ea, fa};
    assign {es, fs} = swap ? {ea, fa} : {eb, fb};
    assign d = el - es;
    assign shifted = {fs, {(XW + 2){1'b0}}} >> d;
    // Beyond the window every significand bit is lost, so only its presence survives as sticky
    assign st = (d >= DLIM) ? |fs : |shifted[XW-1:0];
    assign lx = {1'b0, fl, 3'b000};
    assign sx = {1'b0, shifted[2*XW+1:XW], st};
    assign sum = (sa ^ sb) ? lx - sx : lx + sx;

    // Leading-zero count of the raw sum drives the normalising shift
    always_comb begin
        lz = '0;
        done = 1'b0;
        for (int i = XW + 3; i >= 0; i--) begin
            if (!done && sum[i]) done = 1'b1;
            else if (!done) lz = lz + 1'b1;
        end
    end

    assign norm = sum << lz;
    assign add_e = EX'(el) + EX'(1) - EX'(lz);

    assign p = {{XW{1'b0}}, fa} * {{XW{1'b0}}, fb};
    assign pn = p[2*XW-1] ? p : p << 1;
    assign mul_e = EX'(ea) + EX'(eb) - EX'(BIAS) + EX'(p[2*XW-1]);

    assign e = op_mul ? mul_e : add_e;
    assign m = op_mul ? pn[2*XW-2:XW] : norm[XW+2:4];
    assign x = op_mul ? |pn[XW-1:0] : |norm[3:0];
    assign s = op_mul ? sa ^ sb : sl;
    assign ovf = !e[EX-1] && e[EX-2:0] >= {1'b0, EMAX};
    assign unf = e[EX-1] || e == '0;

    // Special operands take priority over the arithmetic path; overflow is never exact
    always_comb begin
        res = {s, e[EW-1:0], m};
        flags = {3'b000, x};
        if (na || nb) begin
            res = QNAN;
            flags = '0;
        end else if (op_mul ? (ia && zb) || (ib && za) : ia && ib && (sa != sb)) begin
            res = QNAN;
            flags = 4'b1000;
        end else if (ia || ib) begin
            res = {op_mul ? sa ^ sb : (ia ? sa : sb), EMAX, {MW{1'b0}}};
            flags = '0;
        end else if (op_mul ? za || zb : sum == '0) begin
            res = {op_mul ? sa ^ sb : sa & sb & za & zb, {(W - 1){1'b0}}};
            flags = '0;
        end else if (ovf) begin
            res = {s, EMAX, {MW{1'b0}}};
            flags = 4'b0101;
        end else if (unf) begin
            res = {s, {(W - 1){1'b0}}};
            flags = 4'b0011;
        end
    end
endmodule

// File: rtl/fpu.sv
// fpu: binary32/binary16 add/multiply with sticky exception flags
module fpu
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  FPUControl,
    output logic [31:0] Result,
    output logic [3:0]  Flags
);
    logic is_mul, is_half;
    logic [31:0] r32;
    logic [15:0] r16;
    logic [3:0] f32, f16, op_flags;

    assign is_mul = FPUControl == FP_MUL32 || FPUControl == FP_MUL16;
    assign is_half = FPUControl == FP_ADD16 || FPUControl == FP_MUL16;

    fp_addmul_core #(.EW(8), .MW(23), .BIAS(BIAS32), .QNAN(QNAN32)) u_core32 (
        .a(a), .b(b), .op_mul(is_mul), .res(r32), .flags(f32)
    );

    fp_addmul_core #(.EW(5), .MW(10), .BIAS(BIAS16), .QNAN(QNAN16)) u_core16 (
        .a(a[15:0]), .b(b[15:0]), .op_mul(is_mul), .res(r16), .flags(f16)
    );

    assign Result = is_half ? {16'h0000, r16} : r32;
    assign op_flags = is_half ? f16 : f32;

    // Accumulate exception flags every cycle until reset clears them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) Flags <= '0;
        else Flags <= Flags | op_flags;
    end
endmodule

// File: tb/tb_fpu.sv
// tb_fpu: directed vectors with a queued scoreboard for Result and sticky Flags
module tb_fpu;
    import fpu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0] ctl = FP_ADD32;
    logic [31:0] result;
    logic [3:0] flags;
    logic [3:0] sticky = '0;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    exp_t cur;

    always #5 clk = ~clk;

    fpu dut (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .FPUControl(ctl), .Result(result), .Flags(flags)
    );

    // Drive one vector just after the edge; Flags seen this cycle reflect earlier ops only
    task automatic issue(input string nm, input logic r, input logic [1:0] op,
                         input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] er, input logic [3:0] ef);
        @(posedge clk);
        #1;
        reset = r;
        ctl = op;
        a = va;
        b = vb;
        if (!r) sticky = '0;
        q.push_back(exp_t'{er, sticky, nm});
        if (r) sticky = sticky | ef;
    endtask

    // Monitor compares whatever the DUT presents mid-cycle against the oldest expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            checks++;
            if (result !== cur.res) begin
                errors++;
                $display("FAIL %s result: got %h expected %h", cur.name, result, cur.res);
            end
            checks++;
            if (flags !== cur.fl) begin
                errors++;
                $display("FAIL %s flags: got %b expected %b", cur.name, flags, cur.fl);
            end
        end
    end

    initial begin
        issue("reset_add32",   1'b0, FP_ADD32, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000);
        issue("add32_cancel",  1'b1, FP_ADD32, 32'h3F800000, 32'hBF800000, 32'h00000000, 4'b0000);
        issue("mul32_2x3",     1'b1, FP_MUL32, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);
        issue("mul32_zero",    1'b1, FP_MUL32, 32'h00000000, 32'h40400000, 32'h00000000, 4'b0000);
        issue("add16_1p2",     1'b1, FP_ADD16, 32'h00003C00, 32'h00004000, 32'h00004200, 4'b0000);
        issue("add16_upper",   1'b1, FP_ADD16, 32'hFFFF3C00, 32'hABCD4000, 32'h00004200, 4'b0000);
        issue("mul16_1p5x2",   1'b1, FP_MUL16, 32'h00003E00, 32'h00004000, 32'h00004200, 4'b0000);
        issue("mul16_neg",     1'b1, FP_MUL16, 32'h0000C000, 32'h00003C00, 32'h0000C000, 4'b0000);
        issue("add32_borrow",  1'b1, FP_ADD32, 32'h40000000, 32'hBF800000, 32'h3F800000, 4'b0000);
        issue("add16_negbig",  1'b1, FP_ADD16, 32'h00003C00, 32'h0000C400, 32'h0000C200, 4'b0000);
        issue("add32_subnorm", 1'b1, FP_ADD32, 32'h00000001, 32'h3F800000, 32'h3F800000, 4'b0000);
        issue("add32_inf",     1'b1, FP_ADD32, INF32,        32'h3F800000, INF32,        4'b0000);
        issue("mul16_infneg",  1'b1, FP_MUL16, 32'h00007C00, 32'h0000BC00, 32'h0000FC00, 4'b0000);
        issue("add16_nan",     1'b1, FP_ADD16, 32'h00007E00, 32'h00003C00, 32'h00007E00, 4'b0000);
        issue("add32_inexact", 1'b1, FP_ADD32, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001);
        issue("mul32_inexact", 1'b1, FP_MUL32, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        issue("mul32_under",   1'b1, FP_MUL32, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
        issue("mul32_over",    1'b1, FP_MUL32, 32'h7F7FFFFF, 32'h40000000, INF32,        4'b0101);
        issue("add32_infinf",  1'b1, FP_ADD32, INF32,        32'hFF800000, QNAN32,       4'b1000);
        issue("mul16_0xinf_r", 1'b0, FP_MUL16, 32'h00000000, 32'h00007C00, 32'h00007E00, 4'b1000);
        issue("after_reset",   1'b1, FP_ADD32, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0000);
        issue("mul16_0xinf",   1'b1, FP_MUL16, 32'h00000000, 32'h00007C00, 32'h00007E00, 4'b1000);
        issue("final_flags",   1'b1, FP_ADD32, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0000);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
